// File: rtl/multi_rate_blinker_pkg.sv
// rtl/multi_rate_blinker_pkg.sv - shared widths, mode encodings and half-period helper for the blinker
package multi_rate_blinker_pkg;

    typedef enum logic {
        MODE_SQUARE = 1'b0,
        MODE_STROBE = 1'b1
    } mode_e;

    function automatic int unsigned rate_w(input int unsigned num_rates);
        return (num_rates > 1) ? $clog2(num_rates) : 1;
    endfunction

    function automatic int unsigned sel_w(input int unsigned num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    function automatic logic [63:0] half_period(input logic [63:0] base_ticks,
                                                input int unsigned idx);
        return base_ticks << idx;
    endfunction

endpackage

// File: rtl/multi_rate_blinker_blink_channel.sv
// rtl/multi_rate_blinker_blink_channel.sv - one light channel: rate index, countdown, toggle flop, mode mux
module blink_channel
    import multi_rate_blinker_pkg::*;
#(
    parameter int unsigned NUM_RATES  = 4,
    parameter int unsigned BASE_TICKS = 1000000,
    parameter int unsigned CNT_W      = 32,
    localparam int unsigned RW        = rate_w(NUM_RATES)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          en_i,
    input  logic          mode_i,
    input  logic          inc_i,
    input  logic          dec_i,
    output logic [RW-1:0] idx_o,
    output logic          out_o
);

    localparam logic [RW-1:0]    MAX_IDX   = RW'(NUM_RATES - 1);
    localparam logic [CNT_W-1:0] RESET_CNT = CNT_W'(BASE_TICKS - 1);

    logic [RW-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tog_q, tog_d;
    logic             out_q, out_d;
    logic [CNT_W-1:0] reload;
    logic             tick;

    always_comb begin
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        tog_d  = tog_q;
        tick   = 1'b0;
        if (inc_i && !dec_i && idx_q != MAX_IDX) begin
            idx_d = idx_q + RW'(1);
        end else if (dec_i && !inc_i && idx_q != '0) begin
            idx_d = idx_q - RW'(1);
        end
        reload = CNT_W'(half_period(64'(BASE_TICKS), 32'(idx_d)) - 64'd1);

        // A rate change restarts the period without touching the output level.
        if (!en_i) begin
            cnt_d = reload;
            tog_d = 1'b0;
        end else if (idx_d != idx_q) begin
            cnt_d = reload;
        end else if (cnt_q == '0) begin
            cnt_d = reload;
            tick  = 1'b1;
            tog_d = ~tog_q;
        end else begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        out_d = en_i && ((mode_i == MODE_STROBE) ? tick : tog_d);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q <= '0;
            cnt_q <= RESET_CNT;
            tog_q <= 1'b0;
            out_q <= 1'b0;
        end else begin
            idx_q <= idx_d;
            cnt_q <= cnt_d;
            tog_q <= tog_d;
            out_q <= out_d;
        end
    end

    assign idx_o = idx_q;
    assign out_o = out_q;

endmodule

// File: rtl/multi_rate_blinker.sv
// rtl/multi_rate_blinker.sv - button edge detect, channel select decode and per-channel blinker array
module multi_rate_blinker
    import multi_rate_blinker_pkg::*;
#(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned NUM_RATES  = 4,
    parameter int unsigned BASE_TICKS = 1000000,
    parameter int unsigned CNT_W      = 32,
    localparam int unsigned RW        = rate_w(NUM_RATES),
    localparam int unsigned SW        = sel_w(NUM_CH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 shift_left,
    input  logic                 shift_right,
    input  logic [SW-1:0]        ch_sel,
    input  logic [NUM_CH-1:0]    ch_en,
    input  logic [NUM_CH-1:0]    mode,
    output logic [NUM_CH-1:0]    out_light,
    output logic [NUM_CH*RW-1:0] rate_idx
);

    logic left_prev_q, right_prev_q;
    logic left_edge_q, right_edge_q;
    logic left_edge_d, right_edge_d;

    assign left_edge_d  = shift_left  & ~left_prev_q;
    assign right_edge_d = shift_right & ~right_prev_q;

    // Edges are registered so rate steps land two cycles after the button level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            left_prev_q  <= 1'b0;
            right_prev_q <= 1'b0;
            left_edge_q  <= 1'b0;
            right_edge_q <= 1'b0;
        end else begin
            left_prev_q  <= shift_left;
            right_prev_q <= shift_right;
            left_edge_q  <= left_edge_d;
            right_edge_q <= right_edge_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic          sel_hit;
        logic [RW-1:0] ch_idx;
        logic          ch_out;

        assign sel_hit = (ch_sel == SW'(i));

        blink_channel #(
            .NUM_RATES  (NUM_RATES),
            .BASE_TICKS (BASE_TICKS),
            .CNT_W      (CNT_W)
        ) u_ch (
            .clk_i  (clk),
            .rst_ni (rst),
            .en_i   (ch_en[i]),
            .mode_i (mode[i]),
            .inc_i  (right_edge_q & sel_hit),
            .dec_i  (left_edge_q & sel_hit),
            .idx_o  (ch_idx),
            .out_o  (ch_out)
        );

        assign out_light[i]          = ch_out;
        assign rate_idx[i*RW +: RW]  = ch_idx;
    end

endmodule

// File: doc/multi_rate_blinker.md
Name: multi_rate_blinker

Overview:
Multi-channel programmable blinker. Each channel drives one light at a programmable rate and blink mode. Two user buttons step the rate of the currently selected channel. Sits between the debounced button inputs and the LED outputs; it replaces the single-channel shifter + timer + blinker chain with one parametrised block.

Parameters:
NUM_CH, 4, number of independent light channels (1..16)
NUM_RATES, 4, number of rate levels per channel (2..8); rate index width RW = clog2(NUM_RATES)
BASE_TICKS, 1000000, half-period in clk cycles at rate index 0 (>= 2)
CNT_W, 32, countdown counter width; must hold BASE_TICKS << (NUM_RATES-1)

Ports:
clk  in  1  system clock; all state on rising edge
rst  in  1  asynchronous, active-low reset
shift_left  in  1  "faster" button level, synchronous, debounced
shift_right  in  1  "slower" button level, synchronous, debounced
ch_sel  in  clog2(NUM_CH)  channel the buttons act on; values >= NUM_CH are ignored
ch_en  in  NUM_CH  per-channel enable
mode  in  NUM_CH  per-channel mode: 0 = square blink, 1 = strobe
out_light  out  NUM_CH  light outputs
rate_idx  out  NUM_CH*RW  current rate index per channel, channel 0 in LSBs

Behaviour:
- Reset (rst = 0, async): all rate indices = 0; counters = BASE_TICKS-1; out_light = 0; button edge registers = 0. Outputs stay at these values until the first clk edge after reset is released.
- Button edges: each button is registered once. A rising edge is (level & ~prev), a single-cycle event; holding a button produces one step.
- Rate stepping, selected channel only, applied the cycle after the edge:
  - left edge only: idx = idx-1, saturating at 0 (shorter period, faster blink).
  - right edge only: idx = idx+1, saturating at NUM_RATES-1.
  - both edges in the same cycle: no change.
  - ch_sel out of range: no change.
- Half-period: HP(idx) = BASE_TICKS << idx cycles.
- Counter, per channel, enabled: counts down by 1 each cycle. When it reaches 0, it reloads HP(idx)-1 and a toggle event fires.
- Rate change: the counter reloads HP(new)-1 in the same cycle the index updates. The output level is unchanged, so there is no runt pulse beyond the restart.
- Mode 0 (square): out toggles on each toggle event, giving a 50% duty cycle with period 2*HP.
- Mode 1 (strobe): out = 1 for exactly the one cycle after each toggle event, otherwise 0. Pulse period is HP.
- A mode change takes effect on the next cycle. The internal toggle flop keeps running in both modes.
- Disabled channel (ch_en bit = 0):
  - counter held at HP(idx)-1, toggle flop cleared, out = 0.
  - rate stepping still applies.
  - on re-enable, the first toggle occurs HP cycles later.
- Latency:
  - button edge to rate_idx update: 2 cycles after the button level rises.
  - enable to first toggle: HP cycles.
- Async reset mid-count immediately forces all reset values, regardless of clk.

Decomposition:
- Shared package multi_rate_blinker_pkg holds:
  - RW / channel-select width derivation functions.
  - Mode encodings MODE_SQUARE = 0 and MODE_STROBE = 1.
  - the HP(idx) shift function.
- Sub-module blink_channel (one instance per channel via generate) contains:
  - rate index register with saturating inc/dec inputs.
  - countdown counter.
  - toggle flop and mode output mux.
- The top level holds only button edge detection, ch_sel decode and output concatenation.

Test Plan:
- Reset: hold rst = 0 with buttons toggling -> out_light = 0, all rate_idx = 0. After release, with NUM_CH = 4, BASE_TICKS = 4, ch_en = 4'b0001, mode = 0 -> out_light[0] rises at cycle 4, falls at cycle 8, period 8.
- Rate step: ch_sel = 2, three right-button presses -> rate_idx[2] = 3. A fourth press -> stays 3. Channel 2 half-period = 32 cycles. Other channels stay at idx 0.
- Saturation and held button: a left press at idx 0 -> stays 0. Holding the right button 20 cycles -> exactly one increment.
- Simultaneous edges: both buttons rise in the same cycle -> no rate change. Out-of-range ch_sel (when NUM_CH = 3, ch_sel = 3) -> no channel changes.
- Strobe mode: mode[1] = 1, idx 1, BASE_TICKS = 4 -> out_light[1] is a single-cycle pulse every 8 cycles. Switching to mode 0 mid-run -> square wave continues on the same toggle schedule.
- Enable and reset mid-operation:
  - clear ch_en[0] mid-period -> out 0 next cycle.
  - set ch_en[0] again -> first rise exactly HP cycles later.
  - assert rst between clock edges -> outputs clear without waiting for clk.
